regfile_read_arbiter: RTL
=========================

Name: regfile_read_arbiter

Overview:
- Shares the single regfile read port (`ctrl_readReg` / `data_readReg`) among NUM_REQ requesters, e.g. decode stage, debug reader, scan/trace unit.
- Round-robin arbitration with a valid/ready request handshake and optional multi-beat locked bursts.
- Returns the read data registered, one cycle after acceptance, tagged with the requester ID.
- Sits between the requesters and the regfile read port; the regfile read path is combinational.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of `rsp_id`; must satisfy 2^ID_W >= NUM_REQ.
- MAX_BURST, 4, maximum accepted beats per lock before a forced release (1..15).

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i presents a read.
- req_reg  in  3*NUM_REQ  slice [3i+2:3i]: register index from requester i.
- req_last  in  NUM_REQ  bit i: this beat ends requester i's burst.
- req_ready  out  NUM_REQ  one-hot or zero; bit i means requester i is granted this cycle.
- ctrl_readReg  out  3  regfile read index.
- data_readReg  in  8  regfile read data (combinational from `ctrl_readReg`).
- rsp_valid  out  1  response valid (single-cycle pulse per beat).
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  8  captured read data.
- locked  out  1  arbiter is in the LOCKED state.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, locked=0.
  - `req_ready` and `ctrl_readReg` evaluate to 0.
- Handshake: beat accepted on a rising edge where req_valid[i] && req_ready[i]; at most one beat per cycle.
- `req_ready` is combinational from state, rr_ptr and req_valid.
- Grant in IDLE: winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[winner]=1.
- Grant in LOCKED: req_ready[owner]=req_valid[owner]; all other ready bits 0.
- `ctrl_readReg` = req_reg slice of the granted requester, else 3'b000.
- Response latency 1 cycle. On an accept edge: rsp_data<=data_readReg, rsp_id<=i, rsp_valid<=1. On any other edge rsp_valid<=0; rsp_data and rsp_id hold.
- Arbitration state transitions:
  - IDLE, accept with req_last=1: stay IDLE, rr_ptr<=(i+1) mod NUM_REQ.
  - IDLE, accept with req_last=0: -> LOCKED, owner<=i, beat_cnt<=1.
  - LOCKED, accept: beat_cnt<=beat_cnt+1. If req_last=1, or beat_cnt+1==MAX_BURST (forced release), -> IDLE, rr_ptr<=(owner+1) mod NUM_REQ, beat_cnt<=0.
  - LOCKED, owner req_valid=0: hold the state; no timeout.
  - No requests in IDLE: nothing changes.
- MAX_BURST=1: every accept is treated as last; LOCKED is never entered.
- `locked` = (state==LOCKED), registered.
- Reset mid-burst: lock dropped; any in-flight response is lost (rsp_valid=0).

Optional Feature:
- Macro: RFARB_FIXED_PRIO_EN.
- Defined: in IDLE, requester 0 wins whenever req_valid[0]=1; the others are round-robin among themselves via rr_ptr. An active LOCKED burst of another owner is never preempted. rr_ptr updates only when a non-zero requester wins.
- Undefined: pure round-robin as described above.

Test Plan:
- Reset released with no requests -> req_ready=000, ctrl_readReg=0, rsp_valid stays 0 for 5 cycles.
- Single read: req_valid=001, req_reg[0]=5, last=1, regfile r5=8'h3C -> ready=001 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'h3C; rr_ptr=1.
- Round-robin: all three valid with last=1 for 6 cycles -> grant order 0,1,2,0,1,2; rsp_id follows one cycle later.
- Lock: req1 issues 3 beats (last=0,0,1) to regs 2,3,4 while req0 and req2 stay valid -> only req1 is ready for those 3 accepts; locked=1 from after beat 1 until after beat 3; next grant goes to req2.
- Forced release: MAX_BURST=4, req2 holds last=0 for 6 cycles -> exactly 4 accepts, then IDLE and req0 is granted; with RFARB_FIXED_PRIO_EN, req0 still waits until the forced release.
- Reset asserted between the 2nd and 3rd beats of a burst -> locked=0, rsp_valid=0 immediately; after release, req0 (rr_ptr=0) wins first.

Source files
------------

// File: rtl/regfile_read_arbiter_if.sv
// Bundle of requester, regfile read-port and response signals for regfile_read_arbiter.
// master: the environment side (requesters + regfile); slave: the arbiter.
interface regfile_read_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_reg;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           ctrl_readReg;
  logic [7:0]           data_readReg;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;
  logic                 locked;

  modport master (
    output req_valid, req_reg, req_last, data_readReg,
    input  req_ready, ctrl_readReg, rsp_valid, rsp_id, rsp_data, locked
  );

  modport slave (
    input  req_valid, req_reg, req_last, data_readReg,
    output req_ready, ctrl_readReg, rsp_valid, rsp_id, rsp_data, locked
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one combinational regfile read port among NUM_REQ requesters,
// with locked multi-beat bursts (forced release after MAX_BURST beats) and a registered,
// ID-tagged response one cycle after each accepted beat.
// Optional macro RFARB_FIXED_PRIO_EN: requester 0 has fixed priority in IDLE; the others
// rotate among themselves. An active burst is never preempted.
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_read_arbiter_if.slave bus
);

`ifdef RFARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          r_state, w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0] r_owner, w_owner_nxt;
  logic [3:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [7:0]      r_rsp_data;

  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant_idx;
  logic [ID_W-1:0] w_cand;
  logic [2:0]      w_rd_idx;
  logic            w_last;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pick the granted requester: owner while locked, otherwise rotating scan from rr_ptr
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (reset) begin
      w_grant_vld = 1'b0;
    end else if (r_state == StLocked) begin
      w_grant_vld = bus.req_valid[r_owner];
      w_grant_idx = r_owner;
    end else if (FixedPrio && bus.req_valid[0]) begin
      w_grant_vld = 1'b1;
      w_grant_idx = '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        // Under fixed priority requester 0 is handled above, so skip it in the rotation
        if (!w_grant_vld && bus.req_valid[w_cand] && !(FixedPrio && w_cand == '0)) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
  end

  // Route the granted requester's register index to the regfile
  always_comb begin
    w_rd_idx = 3'b000;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (w_grant_vld && w_grant_idx == ID_W'(j)) w_rd_idx = bus.req_reg[3*j +: 3];
    end
  end

  assign w_last           = bus.req_last[w_grant_idx];
  assign bus.req_ready    = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign bus.ctrl_readReg = w_rd_idx;

  // Arbitration next-state: lock on a non-last beat, release on last or beat limit
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    if (w_grant_vld) begin
      unique case (r_state)
        StIdle: begin
          if (w_last || MAX_BURST == 1) begin
            if (!(FixedPrio && w_grant_idx == '0)) w_rr_ptr_nxt = next_ptr(w_grant_idx);
          end else begin
            w_state_nxt    = StLocked;
            w_owner_nxt    = w_grant_idx;
            w_beat_cnt_nxt = 4'd1;
          end
        end
        StLocked: begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
          if (w_last || (r_beat_cnt + 4'd1) == MaxBurst) begin
            w_state_nxt    = StIdle;
            w_beat_cnt_nxt = 4'd0;
            if (!(FixedPrio && r_owner == '0)) w_rr_ptr_nxt = next_ptr(r_owner);
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Arbitration state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Response capture: data and ID hold between beats, valid pulses once per beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_grant_vld) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_idx;
      r_rsp_data  <= bus.data_readReg;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.locked    = (r_state == StLocked);

endmodule
